// File: rtl/instruction_prefetch.sv
// Pipelined instruction prefetch: up to MAX_OUT requests in flight, a
// QDEPTH-entry PC/instruction queue and a registered output stage to decode.
module instruction_prefetch #(
    parameter int unsigned IWIDTH   = 32,
    parameter int unsigned PC_WIDTH = 32,
    parameter int unsigned QDEPTH   = 4,
    parameter int unsigned MAX_OUT  = 2,
    parameter int unsigned PC_STEP  = 4,
    parameter int unsigned RESET_PC = 0
) (
    input  logic                f_clk,
    input  logic                f_rst,
    input  logic                f_i_ce,
    input  logic                f_i_change_pc,
    input  logic [PC_WIDTH-1:0] f_i_pc,
    input  logic                f_i_stall,
    output logic                f_o_syn,
    output logic [PC_WIDTH-1:0] f_o_addr,
    input  logic                f_i_ack,
    input  logic [IWIDTH-1:0]   f_i_data,
    output logic [IWIDTH-1:0]   f_o_instr,
    output logic [PC_WIDTH-1:0] f_o_pc,
    output logic                f_o_ce
);

    localparam int unsigned QAW = $clog2(QDEPTH);
    localparam int unsigned QCW = $clog2(QDEPTH + 1);
    localparam int unsigned FAW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int unsigned OCW = $clog2(MAX_OUT + 1);

    typedef logic [PC_WIDTH-1:0] pc_t;
    typedef logic [IWIDTH-1:0]   ins_t;
    typedef logic [QAW-1:0]      qptr_t;
    typedef logic [QCW-1:0]      qcnt_t;
    typedef logic [FAW-1:0]      fptr_t;
    typedef logic [OCW-1:0]      ocnt_t;
    typedef logic [QCW:0]        credit_t;

    localparam pc_t     PC_INC  = pc_t'(PC_STEP);
    localparam pc_t     PC_RST  = pc_t'(RESET_PC);
    localparam ocnt_t   OUT_MAX = ocnt_t'(MAX_OUT);
    localparam credit_t Q_MAX   = credit_t'(QDEPTH);
    localparam fptr_t   FL_LAST = fptr_t'(MAX_OUT - 1);

    pc_t     fetch_pc;
    pc_t     fl_pc [MAX_OUT];
    fptr_t   fl_wr;
    fptr_t   fl_rd;
    ocnt_t   outstanding;
    ocnt_t   discard;
    pc_t     q_pc  [QDEPTH];
    ins_t    q_ins [QDEPTH];
    qptr_t   q_wr;
    qptr_t   q_rd;
    qcnt_t   q_count;

    logic    issue;
    logic    ack_v;
    logic    q_push;
    logic    q_pop;
    ocnt_t   out_next;
    credit_t credit;

    function automatic fptr_t fl_inc(input fptr_t p);
        return (p == FL_LAST) ? '0 : p + fptr_t'(1);
    endfunction

    // Credits count queued entries plus in-flight requests, so every
    // response that comes back is guaranteed a queue slot.
    always_comb begin
        credit   = credit_t'(q_count) + credit_t'(outstanding);
        ack_v    = f_i_ack && (outstanding != '0);
        issue    = f_i_ce && !f_i_change_pc
                   && (outstanding < OUT_MAX) && (credit < Q_MAX);
        q_push   = ack_v && (discard == '0) && !f_i_change_pc;
        q_pop    = !f_i_change_pc && (q_count != '0)
                   && (!f_o_ce || !f_i_stall);
        out_next = outstanding;
        if (issue && !ack_v) begin
            out_next = outstanding + ocnt_t'(1);
        end else if (!issue && ack_v) begin
            out_next = outstanding - ocnt_t'(1);
        end
    end

    always_ff @(posedge f_clk or negedge f_rst) begin
        if (!f_rst) begin
            fetch_pc    <= PC_RST;
            fl_wr       <= '0;
            fl_rd       <= '0;
            outstanding <= '0;
            discard     <= '0;
            q_wr        <= '0;
            q_rd        <= '0;
            q_count     <= '0;
            f_o_syn     <= 1'b0;
            f_o_addr    <= '0;
            f_o_ce      <= 1'b0;
            f_o_instr   <= '0;
            f_o_pc      <= '0;
        end else begin
            f_o_syn     <= issue;
            outstanding <= out_next;

            if (issue) begin
                f_o_addr <= fetch_pc;
                fetch_pc <= fetch_pc + PC_INC;
                fl_wr    <= fl_inc(fl_wr);
            end
            if (f_i_change_pc) begin
                fetch_pc <= f_i_pc;
            end

            if (ack_v) begin
                fl_rd <= fl_inc(fl_rd);
                if (discard != '0) begin
                    discard <= discard - ocnt_t'(1);
                end
            end
            // Everything still in flight at a redirect is stale.
            if (f_i_change_pc) begin
                discard <= out_next;
            end

            if (f_i_change_pc) begin
                q_wr    <= '0;
                q_rd    <= '0;
                q_count <= '0;
            end else begin
                if (q_push) begin
                    q_wr <= q_wr + qptr_t'(1);
                end
                if (q_pop) begin
                    q_rd <= q_rd + qptr_t'(1);
                end
                if (q_push && !q_pop) begin
                    q_count <= q_count + qcnt_t'(1);
                end else if (!q_push && q_pop) begin
                    q_count <= q_count - qcnt_t'(1);
                end
            end

            if (f_i_change_pc) begin
                f_o_ce <= 1'b0;
            end else if (q_pop) begin
                f_o_ce    <= 1'b1;
                f_o_instr <= q_ins[q_rd];
                f_o_pc    <= q_pc[q_rd];
            end else if (!f_i_stall) begin
                f_o_ce <= 1'b0;
            end
        end
    end

    always_ff @(posedge f_clk) begin
        if (issue) begin
            fl_pc[fl_wr] <= fetch_pc;
        end
        if (q_push) begin
            q_pc[q_wr]  <= fl_pc[fl_rd];
            q_ins[q_wr] <= f_i_data;
        end
    end

endmodule

// File: tb/tb_instruction_prefetch.sv
// Bench for instruction_prefetch: in-order memory model with variable
// latency, expected fetch/decode streams tracked from PC arithmetic.
module tb_instruction_prefetch;

    localparam int QDEPTH  = 4;
    localparam int MAX_OUT = 2;
    localparam int STEP    = 4;

    logic        f_clk = 1'b0;
    logic        f_rst = 1'b0;
    logic        f_i_ce = 1'b0;
    logic        f_i_change_pc = 1'b0;
    logic [31:0] f_i_pc = '0;
    logic        f_i_stall = 1'b0;
    logic        f_o_syn;
    logic [31:0] f_o_addr;
    logic        f_i_ack = 1'b0;
    logic [31:0] f_i_data = '0;
    logic [31:0] f_o_instr;
    logic [31:0] f_o_pc;
    logic        f_o_ce;

    instruction_prefetch #(
        .IWIDTH(32), .PC_WIDTH(32), .QDEPTH(QDEPTH),
        .MAX_OUT(MAX_OUT), .PC_STEP(STEP), .RESET_PC(0)
    ) dut (
        .f_clk(f_clk), .f_rst(f_rst), .f_i_ce(f_i_ce),
        .f_i_change_pc(f_i_change_pc), .f_i_pc(f_i_pc),
        .f_i_stall(f_i_stall), .f_o_syn(f_o_syn), .f_o_addr(f_o_addr),
        .f_i_ack(f_i_ack), .f_i_data(f_i_data), .f_o_instr(f_o_instr),
        .f_o_pc(f_o_pc), .f_o_ce(f_o_ce)
    );

    always #5 f_clk = ~f_clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    typedef struct {
        bit ce;
        bit stall;
        int lat;
        int ncyc;
        bit chk;
        bit e_syn;
        bit e_ce;
    } phase_t;

    req_t        memq[$];
    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          lat = 0;
    int          out_cnt = 0;
    int          issued = 0;
    int          presented = 0;
    logic [31:0] exp_addr = '0;
    logic [31:0] exp_pc = '0;
    logic        prev_ce = 1'b0;
    logic [31:0] prev_pc = '0;
    logic [31:0] prev_instr = '0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    task automatic chk(input bit ok, input string nm,
                       input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
        end
    endtask

    task automatic reset_model();
        memq.delete();
        out_cnt   = 0;
        issued    = 0;
        presented = 0;
        exp_addr  = '0;
        exp_pc    = '0;
        prev_ce   = 1'b0;
        f_i_ack   = 1'b0;
        f_i_data  = '0;
    endtask

    // One clock: apply current inputs, then check what the edge produced.
    task automatic cycle();
        logic        ack_e;
        logic        st_e;
        logic        rd_e;
        logic [31:0] tg_e;
        ack_e = f_i_ack;
        st_e  = f_i_stall;
        rd_e  = f_i_change_pc;
        tg_e  = f_i_pc;
        @(posedge f_clk);
        @(negedge f_clk);
        cyc++;
        if (ack_e) out_cnt--;
        if (rd_e) begin
            exp_addr = tg_e;
            exp_pc   = tg_e;
        end
        if (f_o_syn) begin
            chk(f_o_addr == exp_addr, "req_addr", f_o_addr, exp_addr);
            chk(!rd_e, "syn_in_redirect", 32'(f_o_syn), 32'd0);
            memq.push_back('{addr: f_o_addr, due: cyc + lat});
            exp_addr += STEP;
            out_cnt++;
            issued++;
        end
        chk(out_cnt <= MAX_OUT, "max_outstanding", 32'(out_cnt), MAX_OUT);
        if (rd_e) begin
            chk(!f_o_ce, "ce_after_redirect", 32'(f_o_ce), 32'd0);
        end else if (prev_ce && st_e) begin
            chk(f_o_ce && f_o_pc == prev_pc && f_o_instr == prev_instr,
                "stall_hold", f_o_pc, prev_pc);
        end else if (f_o_ce) begin
            chk(f_o_pc == exp_pc, "out_pc", f_o_pc, exp_pc);
            chk(f_o_instr == mem_data(exp_pc), "out_instr",
                f_o_instr, mem_data(exp_pc));
            exp_pc += STEP;
            presented++;
        end
        prev_ce    = f_o_ce;
        prev_pc    = f_o_pc;
        prev_instr = f_o_instr;
        f_i_change_pc = 1'b0;
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            f_i_ack  = 1'b1;
            f_i_data = mem_data(memq[0].addr);
            void'(memq.pop_front());
        end else begin
            f_i_ack  = 1'b0;
            f_i_data = $urandom;
        end
    endtask

    phase_t ph [5];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        int p0;

        ph[0] = '{ce: 1, stall: 0, lat: 0, ncyc: 20, chk: 1, e_syn: 1, e_ce: 1};
        ph[1] = '{ce: 1, stall: 1, lat: 0, ncyc: 10, chk: 1, e_syn: 0, e_ce: 1};
        ph[2] = '{ce: 1, stall: 0, lat: 0, ncyc: 8,  chk: 1, e_syn: 1, e_ce: 1};
        ph[3] = '{ce: 1, stall: 0, lat: 3, ncyc: 30, chk: 0, e_syn: 0, e_ce: 0};
        ph[4] = '{ce: 0, stall: 0, lat: 1, ncyc: 12, chk: 1, e_syn: 0, e_ce: 0};

        reset_model();
        cycle();
        cycle();
        chk({f_o_syn, f_o_ce, f_o_addr, f_o_pc, f_o_instr} == '0,
            "reset_outputs", f_o_addr | f_o_pc | f_o_instr, 32'd0);
        f_rst = 1'b1;

        for (int i = 0; i < 5; i++) begin
            f_i_ce    = ph[i].ce;
            f_i_stall = ph[i].stall;
            lat       = ph[i].lat;
            p0        = presented;
            for (int c = 0; c < ph[i].ncyc; c++) cycle();
            if (ph[i].chk) begin
                chk(f_o_syn == ph[i].e_syn, $sformatf("phase%0d_syn", i),
                    32'(f_o_syn), 32'(ph[i].e_syn));
                chk(f_o_ce == ph[i].e_ce, $sformatf("phase%0d_ce", i),
                    32'(f_o_ce), 32'(ph[i].e_ce));
            end
            if (ph[i].stall) begin
                chk(issued - presented == QDEPTH, "stall_credit_fill",
                    32'(issued - presented), QDEPTH);
            end
            if (i == 0) begin
                chk(presented - p0 == ph[i].ncyc - 2, "stream_no_bubble",
                    32'(presented - p0), 32'(ph[i].ncyc - 2));
            end
        end

        // Redirect with two requests in flight.
        f_i_ce = 1'b1;
        f_i_stall = 1'b0;
        lat = 3;
        found = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            cycle();
            found = (out_cnt == 2);
        end
        chk(found, "two_outstanding", 32'(out_cnt), 32'd2);
        f_i_change_pc = 1'b1;
        f_i_pc = 32'h100;
        lat = 1;
        cycle();
        found = 0;
        for (int c = 0; c < 30 && !found; c++) begin
            cycle();
            found = f_o_ce;
        end
        chk(found && f_o_pc == 32'h100, "first_pc_after_redirect",
            f_o_pc, 32'h100);
        chk(found && f_o_instr == mem_data(32'h100),
            "first_instr_after_redirect", f_o_instr, mem_data(32'h100));

        // Redirect landing on an ack while decode is stalled.
        lat = 2;
        found = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            cycle();
            found = f_o_ce;
        end
        f_i_stall = 1'b1;
        found = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            found = f_i_ack && f_o_ce;
            if (!found) cycle();
        end
        chk(found, "ack_with_stall_found", 32'(found), 32'd1);
        f_i_change_pc = 1'b1;
        f_i_pc = 32'h200;
        cycle();
        chk(!f_o_ce, "redirect_stall_ce", 32'(f_o_ce), 32'd0);
        chk(32'(dut.discard) == 32'(out_cnt), "discard_count",
            32'(dut.discard), 32'(out_cnt));
        f_i_stall = 1'b0;
        found = 0;
        for (int c = 0; c < 30 && !found; c++) begin
            cycle();
            found = f_o_ce;
        end
        chk(found && f_o_pc == 32'h200, "pc_after_stalled_redirect",
            f_o_pc, 32'h200);

        // Randomised traffic.
        p0 = presented;
        for (int c = 0; c < 500; c++) begin
            f_i_ce    = ($urandom_range(9) < 8);
            f_i_stall = ($urandom_range(9) < 3);
            lat       = $urandom_range(3);
            if ($urandom_range(29) == 0) begin
                f_i_change_pc = 1'b1;
                f_i_pc = 32'($urandom_range(1023)) << 2;
            end
            cycle();
        end
        chk(presented - p0 > 50, "random_progress",
            32'(presented - p0), 32'd51);

        // Asynchronous reset between edges.
        f_i_ce = 1'b1;
        f_i_stall = 1'b0;
        lat = 0;
        for (int c = 0; c < 6; c++) cycle();
        #2 f_rst = 1'b0;
        #1;
        chk({f_o_syn, f_o_ce, f_o_addr, f_o_pc, f_o_instr} == '0,
            "async_reset_outputs", f_o_addr | f_o_pc | f_o_instr, 32'd0);
        reset_model();
        cycle();
        cycle();
        f_rst = 1'b1;
        cycle();
        chk(f_o_syn && f_o_addr == 32'd0, "restart_addr", f_o_addr, 32'd0);
        for (int c = 0; c < 12; c++) cycle();
        chk(presented >= 8, "restart_stream", 32'(presented), 32'd8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_prefetch.md
Name: instruction_prefetch

Overview:
Parametrised successor to the single-request fetch stage. It keeps up to MAX_OUT instruction-memory requests in flight over a syn/ack handshake. Returned instructions are buffered with their PCs in a QDEPTH-entry prefetch queue, which feeds a registered output stage towards decode with stall backpressure. A PC redirect (branch/jump) flushes the queue and discards stale in-flight responses.

Parameters:
IWIDTH, 32, instruction width in bits
PC_WIDTH, 32, program counter width in bits
QDEPTH, 4, prefetch queue entries (power of 2, >=2)
MAX_OUT, 2, maximum outstanding memory requests (power of 2, >=1, <=QDEPTH)
PC_STEP, 4, PC increment per fetched instruction
RESET_PC, 0, fetch address after reset

Ports:
f_clk  in  1  clock, all state updates on rising edge
f_rst  in  1  asynchronous active-low reset
f_i_ce  in  1  fetch enable; gates new request issue only
f_i_change_pc  in  1  redirect strobe, one cycle
f_i_pc  in  PC_WIDTH  redirect target, sampled when f_i_change_pc=1
f_i_stall  in  1  decode cannot accept the output this cycle
f_o_syn  out  1  memory request valid; memory accepts every asserted cycle
f_o_addr  out  PC_WIDTH  request address
f_i_ack  in  1  response valid; responses return in request order, latency >=1
f_i_data  in  IWIDTH  response instruction
f_o_instr  out  IWIDTH  instruction to decode
f_o_pc  out  PC_WIDTH  PC of f_o_instr
f_o_ce  out  1  f_o_instr/f_o_pc valid

Behaviour:
- Reset (f_rst=0, async): fetch_pc=RESET_PC; queue, in-flight PC FIFO, outstanding and discard counters are 0. f_o_syn=0, f_o_addr=0, f_o_ce=0, f_o_instr=0, f_o_pc=0. Every output is registered.
- Issue: f_o_syn registered high for a cycle when f_i_ce=1 and f_i_change_pc=0 and outstanding<MAX_OUT and (queue_count+outstanding)<QDEPTH. The credit check guarantees every response has a queue slot. f_o_addr=fetch_pc. On each issue, fetch_pc+=PC_STEP (wraps modulo 2^PC_WIDTH) and the address is pushed to the in-flight PC FIFO. At most one issue per cycle.
- Outstanding count: +1 on issue, -1 on f_i_ack. If both occur in the same cycle, it is unchanged.
- Response: on f_i_ack with discard=0, {in-flight PC head, f_i_data} is pushed into the queue and the in-flight head is popped. With discard>0, the response is dropped, the in-flight head is popped and discard decrements.
- f_i_ack while outstanding=0 is ignored. This is a protocol error and requires no recovery.
- Output stage: when (f_o_ce=0 or f_i_stall=0) and the queue is non-empty, the head is loaded into f_o_instr/f_o_pc, f_o_ce<=1 and the head is popped. If the queue is empty and f_i_stall=0, f_o_ce<=0. While f_o_ce=1 and f_i_stall=1, the outputs hold.
- Latency: an ack at edge N is registered in the queue. f_o_ce rises at edge N+1 if the output stage is free. Queue push and pop in the same cycle are allowed; count is unchanged.
- Redirect (f_i_change_pc=1), effective at that edge:
  - fetch_pc<=f_i_pc.
  - Queue is emptied and f_o_ce<=0, regardless of f_i_stall.
  - No request issues in that cycle.
  - discard <= outstanding after this cycle's ack is accounted for. Any ack in the redirect cycle is itself dropped.
  - Issue resumes the next cycle, subject to the normal credit checks.
  - Back-to-back redirects: the last one wins and discard accumulates correctly.
- f_i_ce=0: issue stops. Outstanding responses still arrive and the queue still drains to decode.
- Full queue: issue blocks by credit; ack never overflows. Empty queue with decode ready: f_o_ce=0 (bubble).
- Reset mid-operation: all state clears immediately; post-reset acks of pre-reset requests are the environment's responsibility.

Test Plan:
- Reset: f_rst=0 for 2 cycles, f_i_ce=0 -> all outputs 0. After release, f_i_ce=1 with a 1-cycle-latency memory -> f_o_addr sequence 0,4,8,… and f_o_pc 0,4,8,… in order, with f_o_ce continuously high after fill.
- Backpressure: f_i_stall=1 for 10 cycles -> f_o_pc holds. f_o_syn stops once queue_count+outstanding=4 (QDEPTH=4). After release, PCs resume with no gap or duplicate.
- Variable latency: memory latency 3 cycles, MAX_OUT=2 -> never more than 2 requests outstanding. Instructions delivered in address order with matching f_o_pc.
- Redirect with 2 outstanding: f_i_change_pc=1, f_i_pc=0x100 -> the next 2 acks are dropped. The first f_o_ce after the redirect shows f_o_pc=0x100 with the matching data; no stale PC ever appears.
- Redirect coinciding with an ack and f_i_stall=1 -> the ack is dropped and f_o_ce=0 next cycle. discard equals the remaining outstanding count.
- Async reset asserted mid-burst (between edges) -> outputs clear before the next edge. fetch_pc restarts at RESET_PC.
